monster_scheduler: RTL and testbench
====================================

Name: monster_scheduler

Overview:
- Controls a pool of monster slots in the Doodle Jump playfield.
- Accumulates per-frame scroll distance and decides when a new monster spawns.
- Selects a free slot, issues that slot's one-cycle `gene` pulse with a randomised spawn position, and routes bullet-hit / stomp kill requests to the slots.
- Sits between the game-state logic (distance, random LFSR, collision detect) and the array of monster instances.

Parameters:
- NUM_SLOTS, 4: number of monster instances managed.
- SPAWN_DIST, 200: scroll pixels accumulated per spawn.
- COOLDOWN_FRAMES, 30: minimum frame ticks after a spawn before the next spawn check.
- SPAWN_Y, 10'd20: fixed spawn row (top of screen, inside visible area).

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  raw vsync-rate frame clock (edge-detected internally)
- distance  in  10  scroll amount for the current frame
- random_num  in  20  free-running LFSR value
- game_over  in  1  level high while the game is lost
- slot_active  in  NUM_SLOTS  active flag from each monster instance
- hit_req  in  NUM_SLOTS  bullet collided with slot i
- beat_req  in  NUM_SLOTS  player stomped slot i
- gene  out  NUM_SLOTS  one-hot, one-cycle spawn pulse
- spawn_x  out  10  spawn centre X, held until the next spawn
- spawn_y  out  10  spawn centre Y, held until the next spawn
- kill  out  NUM_SLOTS  one-cycle remove pulse per slot
- score_inc  out  1  one-cycle pulse per stomp kill
- sched_state  out  3  current FSM state (debug)

Behaviour:
- Reset (asynchronous, active-high) forces all of the following:
  - state = WAIT_DIST; dist_acc = 0; cool_cnt = 0.
  - gene = 0, kill = 0, score_inc = 0.
  - spawn_x = 10'd320, spawn_y = SPAWN_Y.
  - edge-detect flops = 0.
  - Reset asserted mid-operation aborts any pending spawn; no gene pulse is emitted.
- frame_tick is a one-Clk pulse, registered two-flop rising-edge detect of frame_clk; it asserts 2 cycles after the frame_clk edge.
- dist_acc is 12 bits.
  - On each frame_tick while !game_over: dist_acc += distance, saturating at 4095.
- FSM states and transitions:
  - WAIT_DIST: go to PICK when dist_acc >= SPAWN_DIST.
  - PICK: uses the lowest-index i with slot_active[i] = 0.
    - If all slots are active, stay in PICK and re-evaluate every cycle; dist_acc keeps accumulating.
    - Otherwise latch slot_sel, compute spawn_x, and go to SPAWN.
  - SPAWN: exactly one cycle.
    - gene[slot_sel] = 1.
    - dist_acc -= SPAWN_DIST.
    - cool_cnt = 0.
    - Go to COOLDOWN.
  - COOLDOWN: cool_cnt increments on frame_tick; go to WAIT_DIST when cool_cnt == COOLDOWN_FRAMES-1 on a tick.
- spawn_x arithmetic:
  - r = random_num[8:0]; if r >= 280, r -= 280.
  - spawn_x = 180 + r, giving range 180..459 (keeps a 20 px half-width inside 160..479).
  - spawn_x/spawn_y are registered in PICK and valid during the gene cycle.
- Latency: dist_acc crossing the threshold → gene pulse 2 cycles later (PICK, SPAWN), when a free slot exists.
- Kill path, registered, 1-cycle latency:
  - kill[i] <= (hit_req[i] | beat_req[i]) & slot_active[i].
  - score_inc <= |(beat_req & slot_active & ~hit_req); if a bullet and a stomp hit the same slot in the same cycle, the bullet wins and no score is given.
- Simultaneous kill and spawn:
  - A slot being killed is not free until slot_active drops, so gene and kill never target the same slot in the same cycle.
- game_over asserted:
  - Next cycle: state = WAIT_DIST, dist_acc = 0, gene suppressed.
  - kill = slot_active (clear the board every cycle while game_over is high).
  - score_inc = 0.
- Requests on inactive slots are ignored.

Optional Feature:
- Macro: MONSTER_DIFFICULTY_EN.
- Defined:
  - Effective threshold starts at SPAWN_DIST.
  - Threshold drops by 8 after each spawn, floored at SPAWN_DIST/2.
  - Reset and game_over restore it to SPAWN_DIST.
  - Comparison and subtraction both use the effective threshold.
- Undefined: threshold is the constant SPAWN_DIST; no extra registers.

Decomposition:
- Package monster_pkg:
  - sched_state_t enum: WAIT_DIST=0, PICK=1, SPAWN=2, COOLDOWN=3.
  - Constants: X_MIN=160, X_MAX=479, MONSTER_HALF_W=20, SPAWN_X_BASE=180, SPAWN_X_SPAN=280.
- Sub-module slot_picker:
  - Parameterised lowest-index free-slot priority encoder.
  - Outputs: found, index ($clog2(NUM_SLOTS) bits).

Test Plan:
- Reset mid-SPAWN: Reset pulse during PICK → gene never asserts; all outputs at reset values within the same cycle; spawn_x = 320.
- Threshold crossing: distance = 50 for 4 frame ticks → dist_acc = 200 → gene = 4'b0001 exactly one cycle; spawn_x = 180 + (random_num[8:0] mod 280); dist_acc = 0 afterwards.
- Pool full: slot_active = 4'b1111 with dist_acc = 250 → FSM stays in PICK, no gene. Drop slot_active[2] → gene = 4'b0100 two cycles later.
- Cooldown: after a spawn, with distance = 255 per tick → no further gene until 30 frame ticks have elapsed.
- Kill arbitration: slot 1 active, hit_req[1] and beat_req[1] both asserted → kill = 4'b0010 one cycle later, score_inc = 0. beat_req[3] with slot 3 inactive → no kill, no score.
- game_over: assert with slot_active = 4'b1011 and dist_acc = 180 → kill = 4'b1011, dist_acc = 0, state WAIT_DIST, no gene while held.

Source files
------------

// File: rtl/monster_pkg.sv
// monster_pkg: shared types and playfield constants for the monster scheduler.
// Spawn X window is derived from the playfield edges and monster half-width.
package monster_pkg;

  typedef enum logic [2:0] {
    WAIT_DIST = 3'd0,
    PICK      = 3'd1,
    SPAWN     = 3'd2,
    COOLDOWN  = 3'd3
  } sched_state_t;

  localparam int X_MIN          = 160;
  localparam int X_MAX          = 479;
  localparam int MONSTER_HALF_W = 20;

  localparam logic [9:0] SPAWN_X_BASE =
    10'(X_MIN + MONSTER_HALF_W);
  localparam logic [8:0] SPAWN_X_SPAN =
    9'(X_MAX + 1 - X_MIN - 2 * MONSTER_HALF_W);
  localparam logic [9:0] SPAWN_X_RESET = 10'd320;

  // Fold a 9-bit random value into the span and offset it to the base.
  function automatic logic [9:0] spawn_x_of(input logic [8:0] r);
    logic [8:0] m;
    m = (r >= SPAWN_X_SPAN) ? r - SPAWN_X_SPAN : r;
    return SPAWN_X_BASE + {1'b0, m};
  endfunction

endpackage

// File: rtl/monster_scheduler_slot_picker.sv
// slot_picker: lowest-index free-slot priority encoder.
// found is low when every slot reports active.
module slot_picker #(
  parameter int NUM_SLOTS = 4,
  parameter int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic [NUM_SLOTS-1:0] slot_active,
  output logic                 found,
  output logic [IW-1:0]        index
);

  // Scan from the top so the lowest free index wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_active[i]) begin
        found = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/monster_scheduler.sv
// monster_scheduler: distance-driven monster spawner and kill router.
// Optional MONSTER_DIFFICULTY_EN shrinks the spawn threshold per spawn.
module monster_scheduler
  import monster_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int SPAWN_DIST      = 200,
  parameter int COOLDOWN_FRAMES = 30,
  parameter logic [9:0] SPAWN_Y = 10'd20
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic [9:0]           distance,
  input  logic [19:0]          random_num,
  input  logic                 game_over,
  input  logic [NUM_SLOTS-1:0] slot_active,
  input  logic [NUM_SLOTS-1:0] hit_req,
  input  logic [NUM_SLOTS-1:0] beat_req,
  output logic [NUM_SLOTS-1:0] gene,
  output logic [9:0]           spawn_x,
  output logic [9:0]           spawn_y,
  output logic [NUM_SLOTS-1:0] kill,
  output logic                 score_inc,
  output logic [2:0]           sched_state
);

  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

  sched_state_t   state, state_nx;
  logic           f1, f2, frame_tick;
  logic [11:0]    dist_acc;
  logic [CW-1:0]  cool_cnt;
  logic [IW-1:0]  slot_sel;
  logic           found;
  logic [IW-1:0]  free_idx;
  logic [11:0]    thr;
  logic [12:0]    acc_sum;
  logic [11:0]    acc_tick;
  logic           cool_last;
  logic           unused_rnd;

  assign unused_rnd  = ^random_num[19:9];
  assign sched_state = state;

  slot_picker #(
    .NUM_SLOTS(NUM_SLOTS),
    .IW       (IW)
  ) u_picker (
    .slot_active(slot_active),
    .found      (found),
    .index      (free_idx)
  );

  // Two-flop rising-edge detect of frame_clk, registered into a pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      f1         <= 1'b0;
      f2         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      f1         <= frame_clk;
      f2         <= f1;
      frame_tick <= f1 & ~f2;
    end
  end

`ifdef MONSTER_DIFFICULTY_EN
  localparam logic [11:0] THR_MAX   = 12'(SPAWN_DIST);
  localparam logic [11:0] THR_FLOOR = 12'(SPAWN_DIST / 2);

  // Threshold tightens by 8 per spawn down to half the base distance.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      thr <= THR_MAX;
    end else if (game_over) begin
      thr <= THR_MAX;
    end else if (state == SPAWN) begin
      thr <= (thr >= THR_FLOOR + 12'd8) ? thr - 12'd8 : THR_FLOOR;
    end
  end
`else
  assign thr = 12'(SPAWN_DIST);
`endif

  assign acc_sum  = {1'b0, dist_acc} + {3'b000, distance};
  assign acc_tick = !frame_tick ? dist_acc :
                    acc_sum[12] ? 12'hFFF : acc_sum[11:0];
  assign cool_last = cool_cnt == CW'(COOLDOWN_FRAMES - 1);

  // Distance accumulator: saturating add per tick, pay threshold on spawn.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dist_acc <= '0;
    end else if (game_over) begin
      dist_acc <= '0;
    end else if (state == SPAWN) begin
      dist_acc <= acc_tick - thr;
    end else begin
      dist_acc <= acc_tick;
    end
  end

  // Cooldown frame counter, restarted by each spawn.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cool_cnt <= '0;
    end else if (game_over || state == SPAWN) begin
      cool_cnt <= '0;
    end else if (state == COOLDOWN && frame_tick && !cool_last) begin
      cool_cnt <= cool_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= WAIT_DIST;
    else       state <= state_nx;
  end

  // Next-state and spawn pulse decode.
  always_comb begin
    state_nx = state;
    gene     = '0;
    if (game_over) begin
      state_nx = WAIT_DIST;
    end else begin
      unique case (state)
        WAIT_DIST: if (dist_acc >= thr) state_nx = PICK;
        PICK:      if (found) state_nx = SPAWN;
        SPAWN: begin
          gene[slot_sel] = 1'b1;
          state_nx       = COOLDOWN;
        end
        COOLDOWN:  if (frame_tick && cool_last) state_nx = WAIT_DIST;
        default:   state_nx = WAIT_DIST;
      endcase
    end
  end

  // Latch the chosen slot and spawn position while picking.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      slot_sel <= '0;
      spawn_x  <= SPAWN_X_RESET;
      spawn_y  <= SPAWN_Y;
    end else if (state == PICK && found && !game_over) begin
      slot_sel <= free_idx;
      spawn_x  <= spawn_x_of(random_num[8:0]);
      spawn_y  <= SPAWN_Y;
    end
  end

  // Kill routing; a bullet beats a stomp, game over clears the board.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      kill      <= '0;
      score_inc <= 1'b0;
    end else if (game_over) begin
      kill      <= slot_active;
      score_inc <= 1'b0;
    end else begin
      kill      <= (hit_req | beat_req) & slot_active;
      score_inc <= |(beat_req & slot_active & ~hit_req);
    end
  end

endmodule

// File: tb/tb_monster_scheduler.sv
// tb_monster_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a frame/event-level reference model.
module tb_monster_scheduler;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [9:0]  distance;
  logic [19:0] random_num;
  logic        game_over;
  logic [3:0]  slot_active, hit_req, beat_req;
  logic [3:0]  gene, kill;
  logic [9:0]  spawn_x, spawn_y;
  logic        score_inc;
  logic [2:0]  sched_state;

  monster_scheduler dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .distance   (distance),
    .random_num (random_num),
    .game_over  (game_over),
    .slot_active(slot_active),
    .hit_req    (hit_req),
    .beat_req   (beat_req),
    .gene       (gene),
    .spawn_x    (spawn_x),
    .spawn_y    (spawn_y),
    .kill       (kill),
    .score_inc  (score_inc),
    .sched_state(sched_state)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase codes follow the published state numbering.
  int   m_acc, m_phase, m_sel, m_cool, m_x, m_thr;
  logic [3:0] m_kill;
  logic m_score;
  bit   fc_seen1, fc_seen2, tick_due;

  int   gene_pulses;
  logic [3:0] last_gene;
  logic [9:0] last_x;

  function automatic int lowest_free(input logic [3:0] act);
    for (int i = 0; i < 4; i++) if (!act[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_phase = 0; m_sel = 0; m_cool = 0;
    m_x = 320; m_thr = 200; m_kill = '0; m_score = 1'b0;
    fc_seen1 = 0; fc_seen2 = 0; tick_due = 0;
  endtask

  // One clock edge of the game rules, using inputs present at the edge.
  task automatic model_edge();
    bit tick;
    int a, f;
    if (Reset) begin
      model_reset();
      return;
    end
    tick     = tick_due;
    tick_due = fc_seen1 && !fc_seen2;
    fc_seen2 = fc_seen1;
    fc_seen1 = frame_clk;
    if (game_over) begin
      m_kill  = slot_active;
      m_score = 1'b0;
      m_phase = 0; m_acc = 0; m_cool = 0; m_thr = 200;
      return;
    end
    m_kill  = (hit_req | beat_req) & slot_active;
    m_score = |(beat_req & slot_active & ~hit_req);
    a = m_acc;
    if (tick) a = (a + int'(distance) > 4095) ? 4095 : a + int'(distance);
    case (m_phase)
      0: if (m_acc >= m_thr) m_phase = 1;
      1: begin
        f = lowest_free(slot_active);
        if (f >= 0) begin
          m_sel = f;
          m_x = 180 + (int'(random_num[8:0]) % 280);
          m_phase = 2;
        end
      end
      2: begin
        a = a - m_thr;
        m_cool = 0;
        m_phase = 3;
`ifdef MONSTER_DIFFICULTY_EN
        m_thr = (m_thr - 8 < 100) ? 100 : m_thr - 8;
`endif
      end
      default: if (tick) begin
        if (m_cool == 29) m_phase = 0;
        else m_cool++;
      end
    endcase
    m_acc = a;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] eg;
    eg = '0;
    if (m_phase == 2 && !game_over) eg[m_sel] = 1'b1;
    chk({tag, "_gene"}, 32'(gene), 32'(eg));
    chk({tag, "_kill"}, 32'(kill), 32'(m_kill));
    chk({tag, "_score"}, 32'(score_inc), 32'(m_score));
    chk({tag, "_x"}, 32'(spawn_x), 32'(m_x));
    chk({tag, "_y"}, 32'(spawn_y), 32'd20);
    chk({tag, "_state"}, 32'(sched_state), 32'(m_phase));
    if (gene !== 4'b0000) begin
      gene_pulses++;
      last_gene = gene;
      last_x    = spawn_x;
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic frame(input string tag);
    frame_clk = 1'b1;
    repeat (2) cyc(tag);
    frame_clk = 1'b0;
    repeat (2) cyc(tag);
  endtask

  initial begin
    int base;
    Reset = 1'b1; frame_clk = 1'b0; distance = '0;
    random_num = '0; game_over = 1'b0;
    slot_active = '0; hit_req = '0; beat_req = '0;
    gene_pulses = 0; last_gene = '0; last_x = '0;
    model_reset();

    repeat (2) cyc("rst");
    chk("rst_x_const", 32'(spawn_x), 32'd320);
    chk("rst_gene_const", 32'(gene), 32'd0);
    Reset = 1'b0;

    // Threshold crossing: 4 x 50 px.
    random_num = $urandom;
    distance = 10'd50;
    gene_pulses = 0;
    repeat (4) frame("thr");
    repeat (6) cyc("thr");
    chk("thr_pulses", 32'(gene_pulses), 32'd1);
    chk("thr_slot", 32'(last_gene), 32'b0001);
    chk("thr_x", 32'(last_x), 32'(180 + (int'(random_num[8:0]) % 280)));

    // Cooldown: 29 big ticks stay quiet, the 30th releases a spawn.
    distance = 10'd255;
    gene_pulses = 0;
    repeat (29) frame("cool");
    chk("cool_quiet", 32'(gene_pulses), 32'd0);
    frame("cool");
    repeat (4) cyc("cool");
    chk("cool_spawn", 32'(gene_pulses), 32'd1);

    // game_over with 180 px banked.
    game_over = 1'b1;
    cyc("go_pre");
    game_over = 1'b0;
    distance = 10'd60;
    slot_active = 4'b1011;
    repeat (3) frame("go_acc");
    gene_pulses = 0;
    game_over = 1'b1;
    hit_req = 4'b0100;
    beat_req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      cyc("go");
      chk("go_kill_const", 32'(kill), 32'b1011);
      chk("go_state_const", 32'(sched_state), 32'd0);
    end
    game_over = 1'b0;
    hit_req = '0;
    beat_req = '0;
    distance = 10'd70;
    frame("go_post");
    repeat (3) cyc("go_post");
    chk("go_acc_cleared", 32'(sched_state), 32'd0);
    chk("go_no_gene", 32'(gene_pulses), 32'd0);

    // Pool full with 250 px banked, then free slot 2.
    slot_active = 4'b1111;
    distance = 10'd180;
    frame("full");
    repeat (8) cyc("full");
    chk("full_state", 32'(sched_state), 32'd1);
    chk("full_no_gene", 32'(gene_pulses), 32'd0);
    slot_active = 4'b1011;
    repeat (2) cyc("free2");
    chk("free2_pulses", 32'(gene_pulses), 32'd1);
    chk("free2_slot", 32'(last_gene), 32'b0100);

    // Asynchronous reset while parked in PICK.
    game_over = 1'b1;
    cyc("rp_go");
    game_over = 1'b0;
    slot_active = 4'b1111;
    distance = 10'd250;
    frame("rp");
    repeat (3) cyc("rp");
    chk("rp_pick", 32'(sched_state), 32'd1);
    gene_pulses = 0;
    Reset = 1'b1;
    slot_active = 4'b0000;
    #1;
    model_reset();
    check_all("rp_async");
    chk("rp_async_x", 32'(spawn_x), 32'd320);
    repeat (2) cyc("rp_hold");
    Reset = 1'b0;
    repeat (6) cyc("rp_after");
    chk("rp_no_gene", 32'(gene_pulses), 32'd0);

    // Kill arbitration.
    slot_active = 4'b0010;
    hit_req = 4'b0010;
    beat_req = 4'b0010;
    cyc("arb_both");
    chk("arb_both_kill", 32'(kill), 32'b0010);
    chk("arb_both_score", 32'(score_inc), 32'd0);
    hit_req = '0;
    beat_req = 4'b1000;
    cyc("arb_inact");
    chk("arb_inact_kill", 32'(kill), 32'd0);
    chk("arb_inact_score", 32'(score_inc), 32'd0);
    beat_req = 4'b0010;
    cyc("arb_stomp");
    chk("arb_stomp_score", 32'(score_inc), 32'd1);
    beat_req = '0;

    // Randomized traffic.
    base = gene_pulses;
    for (int i = 0; i < 3000; i++) begin
      frame_clk   = (i % 6) < 3;
      distance    = 10'($urandom_range(0, 1023));
      random_num  = 20'($urandom);
      slot_active = 4'($urandom);
      hit_req     = 4'($urandom) & 4'($urandom);
      beat_req    = 4'($urandom) & 4'($urandom);
      game_over   = ($urandom_range(0, 299) == 0);
      cyc("rand");
    end
    chk("rand_spawned", 32'(gene_pulses > base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
